// File: rtl/fetch.sv
// Instruction-fetch stage: holds the PC and drives it as the instruction-memory address.
// Next PC is either the sequential PC + PC_INC or a branch target from a later stage.
module fetch #(
    parameter int              N        = 64,
    parameter logic [N-1:0]    RESET_PC = '0,
    parameter logic [N-1:0]    PC_INC   = N'(4)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         PCSrc_F,
    input  logic [N-1:0] PCBranch_F,
    output logic [N-1:0] imem_addr_F
);

    logic [N-1:0] r_pc;
    logic [N-1:0] w_pc_plus_inc;
    logic [N-1:0] w_pc_next;

    // Modulo-2^N add: the PC wraps silently at the top of the address space.
    assign w_pc_plus_inc = r_pc + PC_INC;
    assign w_pc_next     = PCSrc_F ? PCBranch_F : w_pc_plus_inc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign imem_addr_F = r_pc;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed plan followed by randomized branches and
// async reset pulses, checked against a plain-arithmetic model of the PC.
module tb_fetch;

    logic        clk;
    logic        reset;
    logic        PCSrc_F;
    logic [63:0] PCBranch_F;
    logic [63:0] imem_addr_F;

    int          n_tests;
    int          n_fail;
    logic [63:0] m_pc;

    fetch #(.N(64), .RESET_PC(64'd0), .PC_INC(64'd4)) dut (
        .clk         (clk),
        .reset       (reset),
        .PCSrc_F     (PCSrc_F),
        .PCBranch_F  (PCBranch_F),
        .imem_addr_F (imem_addr_F)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] exp);
        n_tests++;
        assert (imem_addr_F === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, imem_addr_F, exp);
        end
    endtask

    // Drive next-PC inputs, take one rising edge, then check against the model.
    task automatic step(input string tag, input logic src, input logic [63:0] tgt);
        PCSrc_F    = src;
        PCBranch_F = tgt;
        @(posedge clk);
        if (reset) m_pc = src ? tgt : m_pc + 64'd4;
        #1;
        chk(tag, m_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] tgt;
        logic        src;
        n_tests    = 0;
        n_fail     = 0;
        m_pc       = 64'd0;
        reset      = 1'b0;
        PCSrc_F    = 1'b0;
        PCBranch_F = 64'd0;

        #1;
        chk("time0", 64'd0);

        // reset held for 5 cycles, with a branch request that must be ignored
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("reset_hold", 64'd0);
            PCSrc_F    = (i == 3);
            PCBranch_F = 64'h1234;
        end
        PCSrc_F = 1'b0;

        // release mid-cycle; PC holds 0 until the next rising edge
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("release_hold", 64'd0);
        for (int i = 0; i < 5; i++) step("increment", 1'b0, 64'd0);
        chk("reached_20", 64'd20);

        // branch to 16 and hold PCSrc_F
        for (int i = 0; i < 3; i++) step("branch_hold", 1'b1, 64'd16);
        chk("branch_16", 64'd16);

        // async reset mid-run from 0x40
        step("to_0x40", 1'b1, 64'h40);
        chk("at_0x40", 64'h40);
        #2 reset = 1'b0;
        #1 chk("async_clear", 64'd0);
        m_pc = 64'd0;
        step("reset_ignores_branch", 1'b1, 64'hdead_beef);
        PCSrc_F = 1'b0;
        #2 reset = 1'b1;
        step("after_async", 1'b0, 64'd0);
        chk("async_then_4", 64'd4);

        // wrap-around at the top of the address space
        step("to_top", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        step("wrap", 1'b0, 64'd0);
        chk("wrap_zero", 64'd0);

        // unaligned target passes through verbatim
        step("unaligned", 1'b1, 64'h0000_0000_0000_0103);
        step("unaligned_inc", 1'b0, 64'd0);

        // glitches between edges are ignored; only edge values matter
        for (int i = 0; i < 4; i++) begin
            PCSrc_F    = 1'b1;
            PCBranch_F = {$urandom, $urandom};
            #2 chk("glitch_no_effect", m_pc);
            PCSrc_F    = 1'b0;
            PCBranch_F = 64'd0;
            #1;
            step("glitch_restored", 1'b0, 64'd0);
        end

        // randomized run with occasional async reset pulses
        for (int i = 0; i < 300; i++) begin
            src = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
                1:       tgt = 64'($urandom_range(0, 255));
                default: tgt = {$urandom, $urandom};
            endcase
            step("random", src, tgt);
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b0;
                #1 chk("random_async", 64'd0);
                m_pc  = 64'd0;
                #1 reset = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Instruction-fetch stage of the pipelined 64-bit (LEGv8-style) processor.
- Holds the program counter (PC) and drives it as the instruction-memory address.
- Each cycle, the PC advances sequentially by 4, or loads a branch target supplied by a later stage.
- Internal structure: PC register with asynchronous reset, PC+4 adder, 2:1 next-PC mux.

Parameters:
- N, 64: datapath width of PC, branch target and memory address.
- RESET_PC, 0: value the PC takes while reset is asserted.
- PC_INC, 4: sequential increment (bytes per instruction).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- PCSrc_F  in  1  next-PC select: 1 = take PCBranch_F, 0 = sequential PC+4.
- PCBranch_F  in  N  branch/jump target address.
- imem_addr_F  out  N  current PC, used as the instruction-memory address.

Behaviour:
- State: one N-bit PC register.
- imem_addr_F is the PC register output directly; no combinational path from the inputs.
- Reset:
  - reset==0 forces PC to RESET_PC immediately, independent of clk, so imem_addr_F = 0 without waiting for an edge.
  - PC stays at 0 for as long as reset is held low; PCSrc_F and PCBranch_F are ignored.
  - Reset asserted mid-operation clears PC at once; any pending update is discarded.
- Release: after reset goes 1, PC holds 0 until the first rising clk edge, then updates normally.
  - With PCSrc_F==0, the first edge after release gives PC = 4.
- Per rising clk edge with reset==1:
  - PCSrc_F==0: PC <= PC + PC_INC.
  - PCSrc_F==1: PC <= PCBranch_F.
- Latency: one cycle from the next-PC inputs to imem_addr_F.
  - PCSrc_F and PCBranch_F are sampled only at the rising edge; changes between edges have no effect on imem_addr_F.
- Arithmetic:
  - Unsigned, modulo 2^N; PC = 2^N-4 with PCSrc_F==0 wraps to 0. No overflow flag.
  - The branch target is loaded verbatim, with no alignment check. Non-multiple-of-4 values are passed through unchanged.
- PCSrc_F held at 1 reloads PCBranch_F every edge, so the PC stays at the target while the target is constant.
- No stall or flush inputs; the PC updates every cycle outside reset.
- Simulation: output must be 0 at time 0 when reset starts low; no X after the first reset assertion.

Test Plan:
- Reset hold: reset=0 for 5 cycles with clk toggling (10 ns period), PCSrc_F=0 -> imem_addr_F=0 at every sample.
- Release and increment: release reset mid-cycle -> imem_addr_F stays 0 until the next rising edge, then reads 4, 8, 12, 16, 20 on successive edges.
- Branch: after the PC reaches 20, set PCBranch_F=16 and PCSrc_F=1 -> imem_addr_F=16 after the next edge, and stays 16 while PCSrc_F is held.
- Async reset mid-run: with PC=0x40, drive reset=0 between edges -> imem_addr_F=0 immediately, before any clk edge. Release -> 4 on the next edge.
- Wrap-around: branch to 0xFFFF_FFFF_FFFF_FFFC, then PCSrc_F=0 -> next edge gives imem_addr_F=0.
- Input timing: toggle PCSrc_F/PCBranch_F between edges and restore them before the edge -> imem_addr_F unchanged; only the values present at the edge take effect.
